// File: rtl/dbi_encode_32b.sv
// rtl/dbi_encode_32b.sv - AC-DBI transmit encoder with saturating toggle/inversion statistics
//
// Purpose: accepts payload words over a valid/ready handshake and drives a
// registered (bw+1)-bit bus word. Each word is sent either true or inverted,
// whichever causes fewer wire toggles against the word currently on the bus.
// Bit [bw] carries the inversion flag.
//
// Ports:
//   i_clk           rising-edge clock
//   i_reset         asynchronous active-low reset (0 = in reset)
//   i_dbi_en        1 = AC-DBI encoding, 0 = pass-through with flag 0
//   i_in_valid      source word present on i_data_in
//   o_in_ready      encoder accepts i_data_in this cycle
//   i_data_in       payload word
//   o_out_valid     o_data_out holds an encoded word not yet consumed
//   i_out_ready     consumer takes o_data_out this cycle
//   o_data_out      bus word: [bw] = inversion flag, [bw-1:0] = payload or ~payload
//   i_stat_clr      synchronous clear of both statistics counters
//   o_inv_count     words sent inverted (saturating)
//   o_toggle_count  bus-wire toggles caused by accepted words (saturating)

module dbi_encode_32b #(
    parameter int bw = 32,
    parameter int cw = 32,
    parameter int iw = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_dbi_en,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [bw-1:0] i_data_in,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [bw:0]   o_data_out,
    input  logic          i_stat_clr,
    output logic [iw-1:0] o_inv_count,
    output logic [cw-1:0] o_toggle_count
);

    localparam int PW = $clog2(bw + 1);
    localparam logic [PW:0] BW_W = (PW + 1)'(bw);

    logic [bw:0]   r_data_out;
    logic          r_out_valid;
    logic [iw-1:0] r_inv_count;
    logic [cw-1:0] r_toggle_count;

    logic          w_prev_flag;
    logic [bw-1:0] w_prev_data;
    logic [bw-1:0] w_diff;
    logic [PW-1:0] w_pop;
    logic [PW:0]   w_cost_true;
    logic [PW:0]   w_cost_inv;
    logic [PW:0]   w_cost;
    logic          w_invert;
    logic [bw:0]   w_word;
    logic          w_accept;
    logic [cw:0]   w_toggle_sum;
    logic [cw-1:0] w_toggle_next;
    logic [iw-1:0] w_inv_next;

    // The reference is whatever is physically on the bus, which stays parked
    // after a drain, so idle cycles never cost toggles.
    assign w_prev_flag = r_data_out[bw];
    assign w_prev_data = r_data_out[bw-1:0];
    assign w_diff      = i_data_in ^ w_prev_data;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < bw; i++) begin
            w_pop = w_pop + PW'(w_diff[i]);
        end
    end

    // Costs include the flag wire: true form toggles it if it was 1,
    // inverted form toggles it if it was 0.
    assign w_cost_true = {1'b0, w_pop} + (PW + 1)'(w_prev_flag);
    assign w_cost_inv  = (BW_W - {1'b0, w_pop}) + (PW + 1)'(!w_prev_flag);

    // Strict compare: ties keep the true form.
    assign w_invert = i_dbi_en && (w_cost_inv < w_cost_true);
    assign w_cost   = w_invert ? w_cost_inv : w_cost_true;
    assign w_word   = w_invert ? {1'b1, ~i_data_in} : {1'b0, i_data_in};

    assign o_in_ready = !r_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    // One spare bit catches the carry so the counter pins at all-ones.
    assign w_toggle_sum  = {1'b0, r_toggle_count} + (cw + 1)'(w_cost);
    assign w_toggle_next = w_toggle_sum[cw] ? '1 : w_toggle_sum[cw-1:0];
    assign w_inv_next    = (w_invert && (r_inv_count != '1)) ? r_inv_count + iw'(1)
                                                             : r_inv_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_data_out     <= '0;
            r_out_valid    <= 1'b0;
            r_inv_count    <= '0;
            r_toggle_count <= '0;
        end else begin
            if (w_accept) begin
                r_data_out  <= w_word;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Clear takes priority over counting a coincident accept.
            if (i_stat_clr) begin
                r_inv_count    <= '0;
                r_toggle_count <= '0;
            end else if (w_accept) begin
                r_inv_count    <= w_inv_next;
                r_toggle_count <= w_toggle_next;
            end
        end
    end

    assign o_data_out     = r_data_out;
    assign o_out_valid    = r_out_valid;
    assign o_inv_count    = r_inv_count;
    assign o_toggle_count = r_toggle_count;

endmodule

// File: tb/tb_dbi_encode_32b.sv
// tb/tb_dbi_encode_32b.sv - directed and model-checked bench for dbi_encode_32b

module tb_dbi_encode_32b;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dbi_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        out_ready = 1'b0;
    logic        stat_clr = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [32:0] data_out;
    logic [15:0] inv_count;
    logic [31:0] toggle_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [32:0] s_data_out;
    logic [3:0]  s_inv_count;
    logic [7:0]  s_toggle_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbi_encode_32b dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_dbi_en       (dbi_en),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_data_in      (data_in),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_data_out     (data_out),
        .i_stat_clr     (stat_clr),
        .o_inv_count    (inv_count),
        .o_toggle_count (toggle_count)
    );

    dbi_encode_32b #(.bw(32), .cw(8), .iw(4)) dut_sat (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_dbi_en       (dbi_en),
        .i_in_valid     (in_valid),
        .o_in_ready     (s_in_ready),
        .i_data_in      (data_in),
        .o_out_valid    (s_out_valid),
        .i_out_ready    (out_ready),
        .o_data_out     (s_data_out),
        .i_stat_clr     (stat_clr),
        .o_inv_count    (s_inv_count),
        .o_toggle_count (s_toggle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b1;
        dbi_en    = 1'b1;
        data_in   = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        reset     = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 33'h0 || out_valid !== 1'b0 || inv_count !== 16'h0 || toggle_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got do=%h ov=%b inv=%0d tog=%0d want 0/0/0/0", data_out, out_valid, inv_count, toggle_count);
        end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_invert_first();
        do_reset();
        data_in  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (data_out !== 33'h1_0000_0000 || out_valid !== 1'b1 || inv_count !== 16'd1 || toggle_count !== 32'd1) begin
            n_fail++;
            $display("FAIL inv_first got do=%h ov=%b inv=%0d tog=%0d want 100000000/1/1/1", data_out, out_valid, inv_count, toggle_count);
        end
        data_in = 32'h0000_FFFF;
        tick();
        n_checks++;
        if (data_out !== 33'h1_FFFF_0000 || inv_count !== 16'd2 || toggle_count !== 32'd17) begin
            n_fail++;
            $display("FAIL inv_second got do=%h inv=%0d tog=%0d want 1ffff0000/2/17", data_out, inv_count, toggle_count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_true_first();
        do_reset();
        data_in  = 32'h0000_FFFF;
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (data_out !== 33'h0_0000_FFFF || inv_count !== 16'd0 || toggle_count !== 32'd16) begin
            n_fail++;
            $display("FAIL true_first got do=%h inv=%0d tog=%0d want 00000ffff/0/16", data_out, inv_count, toggle_count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_passthrough();
        do_reset();
        dbi_en   = 1'b0;
        data_in  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (data_out !== 33'h0_FFFF_FFFF || inv_count !== 16'd0 || toggle_count !== 32'd32) begin
            n_fail++;
            $display("FAIL passthru got do=%h inv=%0d tog=%0d want 0ffffffff/0/32", data_out, inv_count, toggle_count);
        end
        // flag wire falling from 1 counts as a toggle in pass-through
        do_reset();
        dbi_en   = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        dbi_en  = 1'b0;
        data_in = 32'h0000_0000;
        tick();
        n_checks++;
        if (data_out !== 33'h0 || inv_count !== 16'd1 || toggle_count !== 32'd2) begin
            n_fail++;
            $display("FAIL passthru_flag got do=%h inv=%0d tog=%0d want 0/1/2", data_out, inv_count, toggle_count);
        end
        in_valid = 1'b0;
        dbi_en   = 1'b1;
    endtask

    task automatic test_stall();
        logic [32:0] exp_seq [3];
        int          exp_tog [3];
        logic [31:0] words   [3];
        exp_seq[0] = 33'h0_0000_0003; exp_tog[0] = 2; words[0] = 32'h0000_0003;
        exp_seq[1] = 33'h0_0000_0007; exp_tog[1] = 3; words[1] = 32'h0000_0007;
        exp_seq[2] = 33'h1_0000_000F; exp_tog[2] = 5; words[2] = 32'hFFFF_FFF0;
        do_reset();
        data_in  = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        data_in   = words[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 33'h0_0000_0001 || toggle_count !== 32'd1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got rdy=%b ov=%b do=%h tog=%0d want 0/1/000000001/1", i, in_ready, out_valid, data_out, toggle_count);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = words[i];
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || data_out !== exp_seq[i] || toggle_count !== exp_tog[i]) begin
                n_fail++;
                $display("FAIL stall_flow[%0d] got ov=%b do=%h tog=%0d want 1/%h/%0d", i, out_valid, data_out, toggle_count, exp_seq[i], exp_tog[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== 33'h1_0000_000F || toggle_count !== 32'd5 || inv_count !== 16'd1) begin
            n_fail++;
            $display("FAIL drain_park got ov=%b do=%h tog=%0d inv=%0d want 0/10000000f/5/1", out_valid, data_out, toggle_count, inv_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            data_in = (i % 2 == 1) ? 32'h0000_FFFF : 32'h0000_0000;
            tick();
            if (i >= 15) begin
                n_checks++;
                if (s_toggle_count !== ((i == 15) ? 8'd240 : 8'hFF)) begin
                    n_fail++;
                    $display("FAIL tog_sat[%0d] got %0d want %0d", i, s_toggle_count, (i == 15) ? 240 : 255);
                end
            end
        end
        data_in = 32'h0000_0000;
        tick();
        data_in = 32'hFFFF_FFFF;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 14) begin
                n_checks++;
                if (s_inv_count !== ((i == 14) ? 4'd14 : 4'hF)) begin
                    n_fail++;
                    $display("FAIL inv_sat[%0d] got %0d want %0d", i, s_inv_count, (i == 14) ? 14 : 15);
                end
            end
        end
        stat_clr = 1'b1;
        data_in  = 32'h0000_FFFF;
        tick();
        n_checks++;
        if (s_toggle_count !== 8'd0 || s_inv_count !== 4'd0 || toggle_count !== 32'd0 || inv_count !== 16'd0
            || s_data_out !== 33'h1_FFFF_0000) begin
            n_fail++;
            $display("FAIL stat_clr got stog=%0d sinv=%0d tog=%0d inv=%0d sdo=%h want 0/0/0/0/1ffff0000", s_toggle_count, s_inv_count, toggle_count, inv_count, s_data_out);
        end
        stat_clr = 1'b0;
        data_in  = 32'hFFFF_0000;
        tick();
        n_checks++;
        if (s_toggle_count !== 8'd1 || s_inv_count !== 4'd0 || s_data_out !== 33'h0_FFFF_0000) begin
            n_fail++;
            $display("FAIL after_clr got stog=%0d sinv=%0d sdo=%h want 1/0/0ffff0000", s_toggle_count, s_inv_count, s_data_out);
        end
        for (int i = 0; i < 1000; i++) begin
            data_in = $urandom;
            tick();
        end
        n_checks++;
        if (s_toggle_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL tog_random_sat got %0d want 255", s_toggle_count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_roundtrip();
        logic [32:0] m_bus;
        logic        m_ov;
        int          m_tog;
        int          m_inv;
        logic        acc;
        logic        exp_rdy;
        int          p;
        int          ct;
        int          ci;
        logic [31:0] dec;
        do_reset();
        m_bus = '0;
        m_ov  = 1'b0;
        m_tog = 0;
        m_inv = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            dbi_en    = $urandom_range(0, 1) == 1;
            data_in   = $urandom;
            #1;
            exp_rdy = !m_ov || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, exp_rdy);
            end
            acc = in_valid && exp_rdy;
            if (acc) begin
                p  = $countones(data_in ^ m_bus[31:0]);
                ct = p + int'(m_bus[32]);
                ci = 32 - p + int'(!m_bus[32]);
                if (dbi_en && ci < ct) begin
                    m_bus = {1'b1, ~data_in};
                    m_tog += ci;
                    m_inv += 1;
                end else begin
                    m_bus = {1'b0, data_in};
                    m_tog += ct;
                end
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== m_ov || data_out !== m_bus || toggle_count !== m_tog || inv_count !== m_inv) begin
                n_fail++;
                $display("FAIL rnd_model[%0d] got ov=%b do=%h tog=%0d inv=%0d want %b/%h/%0d/%0d", i, out_valid, data_out, toggle_count, inv_count, m_ov, m_bus, m_tog, m_inv);
            end
            if (acc) begin
                dec = data_out[32] ? ~data_out[31:0] : data_out[31:0];
                n_checks++;
                if (dec !== data_in || (!dbi_en && data_out[32] !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL rnd_decode[%0d] got %h flag=%b want %h", i, dec, data_out[32], data_in);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dbi_en    = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        tick();
        data_in = 32'h0000_FFFF;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 33'h0 || out_valid !== 1'b0 || inv_count !== 16'h0 || toggle_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got do=%h ov=%b inv=%0d tog=%0d want 0/0/0/0", data_out, out_valid, inv_count, toggle_count);
        end
        tick();
        tick();
        n_checks++;
        if (data_out !== 33'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_hold got do=%h ov=%b want 0/0", data_out, out_valid);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (data_out !== 33'h0_0000_FFFF || out_valid !== 1'b1 || toggle_count !== 32'd16 || inv_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_restart got do=%h ov=%b tog=%0d inv=%0d want 00000ffff/1/16/0", data_out, out_valid, toggle_count, inv_count);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_invert_first();
        test_true_first();
        test_passthrough();
        test_stall();
        test_saturation();
        test_random_roundtrip();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbi_encode_32b.md
Name: dbi_encode_32b

Overview:
- Transmit-side data-bus-inversion encoder for the power-efficient systolic-array interconnect.
- Takes bw-bit words through a valid/ready handshake and drives a registered (bw+1)-bit bus word: data in [bw-1:0], inversion flag in [bw].
- Uses AC-DBI. For each word it picks the inverted or true form, whichever gives fewer wire toggles against the word currently on the bus.
- Also keeps saturating statistics counters for power analysis. The existing DBI decoder is the consumer of data_out.

Parameters:
- bw, 32, payload width in bits. Bus width is bw+1.
- cw, 32, width of the toggle_count statistics counter.
- iw, 16, width of the inv_count statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- dbi_en  input  1  1 = AC-DBI encoding; 0 = pass-through with flag forced 0.
- in_valid  input  1  a source word is present on data_in.
- in_ready  output  1  the encoder accepts data_in this cycle.
- data_in  input  bw  payload word.
- out_valid  output  1  data_out holds an encoded word not yet consumed.
- out_ready  input  1  the consumer takes data_out this cycle.
- data_out  output  bw+1  bus word: [bw] = inversion flag, [bw-1:0] = true or inverted payload.
- stat_clr  input  1  synchronous clear of both statistics counters.
- inv_count  output  iw  number of words sent inverted, saturating.
- toggle_count  output  cw  total bus-wire toggles caused by accepted words, saturating.

Behaviour:
- Reset (reset=0, asynchronous): data_out=0, out_valid=0, inv_count=0, toggle_count=0. in_ready reads 1 as soon as reset is released.
- If reset asserts mid-transfer, the pending word is discarded. No partial state survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A word is accepted when in_valid && in_ready.
  - Latency is 1 cycle: an accepted word appears on data_out with out_valid=1 at the next rising edge.
  - Full throughput: one word per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0): data_out and out_valid hold, in_ready=0, counters unchanged.
- Drain (out_ready=1 and no new input accepted): out_valid drops to 0 and data_out keeps its last value. The bus is parked, so an idle cycle causes no toggles.
- Reference for comparison: always the current data_out register (prev_flag = data_out[bw], prev_data = data_out[bw-1:0]). The reference is the last driven value, not the last accepted input.
- Encode decision, with dbi_en=1:
  - p = popcount(data_in ^ prev_data), width clog2(bw+1).
  - cost_true = p + (prev_flag == 1).
  - cost_inv = (bw - p) + (prev_flag == 0).
  - If cost_inv < cost_true, drive {1, ~data_in}. Otherwise drive {0, data_in}.
  - A tie (possible only for odd bw) chooses the true form.
- dbi_en=0: drive {0, data_in}. dbi_en is sampled only on the accept cycle.
- Toggle cost:
  - The cost of the chosen form is the Hamming distance between the new and old data_out.
  - With dbi_en=0 the cost is popcount(data_in ^ prev_data) + prev_flag.
- Counters: on each accept, toggle_count += chosen cost, and inv_count += 1 if the flag is 1.
  - Both saturate at all-ones and never wrap.
  - stat_clr=1 zeroes both counters on that edge. If stat_clr coincides with an accept, the clear wins and the accepted word is not counted.
- Round trip: the decoder with the same dbi_en recovers data_in exactly from data_out.

Test Plan:
- Reset, then accept 0xFFFFFFFF with dbi_en=1 -> next cycle data_out = {1,0x00000000}, out_valid=1, inv_count=1, toggle_count=1.
- Continue from the previous bus {1,0x00000000} and accept 0x0000FFFF:
  - cost_true = 17, cost_inv = 16.
  - -> data_out = {1,0xFFFF0000}, inv_count=2, toggle_count=17.
- From reset, accept 0x0000FFFF -> data_out = {0,0x0000FFFF} (cost_true 16 < cost_inv 17), inv_count=0, toggle_count=16.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, data_out stable, counters frozen. Raise out_ready -> exactly one word per cycle flows with no loss or duplication.
- dbi_en=0 with input 0xFFFFFFFF after bus {0,0} -> data_out = {0,0xFFFFFFFF}, inv_count unchanged, toggle_count += 32.
- Preload toggle_count near saturation (1000 random words with a small cw override, e.g. cw=8), then drive random words -> the counter sticks at 0xFF. Assert stat_clr together with an accept -> both counters read 0.
- Randomized run with the decoder chained on data_out -> every accepted payload is recovered in order.
- Asynchronous reset pulsed mid-stream -> outputs go to 0 immediately and traffic restarts cleanly.
